// File: rtl/adc_seq_pkg.sv
// Shared state encoding, constants and channel-priority helpers for the ADC scan sequencer.
package adc_seq_pkg;

    localparam int AVG_W  = 3;
    localparam int MAX_CH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2
    } state_e;

    function automatic int lowest_set(input logic [MAX_CH-1:0] mask);
        int idx;
        idx = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i]) idx = i;
        end
        return idx;
    endfunction

    // Lowest set bit strictly above cur; when none exists, wraps to the lowest set bit.
    function automatic int next_chan(input logic [MAX_CH-1:0] mask, input int cur,
                                     output logic wrapped);
        int idx;
        idx = -1;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (i > cur && mask[i]) idx = i;
        end
        wrapped = (idx < 0);
        return wrapped ? lowest_set(mask) : idx;
    endfunction

endpackage

// File: rtl/adc_seq_if.sv
// Host-side result stream: tagged ADC results with a valid/ready handshake.
interface adc_seq_if #(
    parameter int DW = 14
) ();
    logic [DW-1:0] data_out;
    logic          data_valid_out;
    logic          data_ready_in;

    modport master (output data_out, data_valid_out, input data_ready_in);
    modport slave  (input data_out, data_valid_out, output data_ready_in);
endinterface

// File: rtl/adc_seq_fifo.sv
// First-word-fall-through result FIFO; a push while full is accepted only alongside a pop.
module adc_seq_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dout_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: storage has no reset; dout_o is forced to zero while empty, so stale words never leak out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// Multi-channel scan controller: gates the SAR core per channel and queues tagged results.
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int MATRIX_BITS   = 12,
    parameter int NUM_CHANNELS  = 4,
    parameter int CH_BITS       = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_in,
    input  logic                          stop_in,
    input  logic                          continuous_in,
    input  logic [NUM_CHANNELS-1:0]       chan_mask_in,
    input  logic [AVG_W*NUM_CHANNELS-1:0] avg_cfg_in,
    input  logic                          adc_conv_finished_in,
    input  logic [MATRIX_BITS-1:0]        adc_result_in,
    output logic                          adc_rst_n_out,
    output logic [AVG_W-1:0]              adc_avg_control_out,
    output logic [CH_BITS-1:0]            chan_sel_out,
    output logic                          busy_out,
    output logic                          overflow_out,
    adc_seq_if.master                     host
);
    localparam int DW = CH_BITS + MATRIX_BITS;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    state_e                    state_q;
    logic [SW-1:0]             settle_q;
    logic [CH_BITS-1:0]        chan_q;
    logic [AVG_W-1:0]          avg_q;
    logic                      adc_rst_n_q;
    logic [NUM_CHANNELS-1:0]   mask_q;
    logic                      cont_q;
    logic                      ovf_q;

    logic                      push;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [DW-1:0]             fifo_dout;
    logic [CH_BITS-1:0]        start_ch;
    logic [CH_BITS-1:0]        run_ch;
    logic [CH_BITS-1:0]        load_ch;
    logic                      run_wrap;
    logic [AVG_W-1:0]          load_avg;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        run_wrap = 1'b0;
        start_ch = CH_BITS'(lowest_set(MAX_CH'(chan_mask_in)));
        run_ch   = CH_BITS'(next_chan(MAX_CH'(mask_q), int'(chan_q), run_wrap));
        load_ch  = (state_q == IDLE) ? start_ch : run_ch;
        load_avg = avg_cfg_in[AVG_W*int'(load_ch) +: AVG_W];
    end

    // A strobe coinciding with stop_in is still captured.
    assign push = (state_q == CONVERT) && adc_conv_finished_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            chan_q      <= '0;
            avg_q       <= '0;
            adc_rst_n_q <= 1'b0;
            mask_q      <= '0;
            cont_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (push && fifo_full && !host.data_ready_in) ovf_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start_in && (|chan_mask_in)) begin
                        mask_q   <= chan_mask_in;
                        cont_q   <= continuous_in;
                        ovf_q    <= 1'b0;
                        chan_q   <= load_ch;
                        avg_q    <= load_avg;
                        settle_q <= SW'(SETTLE_CYCLES);
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (stop_in) begin
                        state_q <= IDLE;
                    end else if (settle_q == SW'(1)) begin
                        state_q     <= CONVERT;
                        adc_rst_n_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q - SW'(1);
                    end
                end
                CONVERT: begin
                    if (stop_in) begin
                        state_q     <= IDLE;
                        adc_rst_n_q <= 1'b0;
                    end else if (adc_conv_finished_in) begin
                        adc_rst_n_q <= 1'b0;
                        if (run_wrap && !cont_q) begin
                            state_q <= IDLE;
                        end else begin
                            chan_q   <= load_ch;
                            avg_q    <= load_avg;
                            settle_q <= SW'(SETTLE_CYCLES);
                            state_q  <= SETTLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    adc_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    adc_seq_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (host.data_ready_in),
        .din_i   ({chan_q, adc_result_in}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dout_o  (fifo_dout)
    );

    assign adc_rst_n_out       = adc_rst_n_q;
    assign adc_avg_control_out = avg_q;
    assign chan_sel_out        = chan_q;
    assign busy_out            = (state_q != IDLE);
    assign overflow_out        = ovf_q;
    assign host.data_out       = fifo_dout;
    assign host.data_valid_out = !fifo_empty;

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
Multi-channel scan controller for the nonbinary SAR ADC control core.
- Selects the analog input channel through `chan_sel_out` and applies a per-channel averaging setting.
- Gates the free-running core through its reset (`adc_rst_n_out`) so each channel gets clean settle and sample phases.
- Captures the core result on the conversion-finished strobe, tags it with the channel number, and buffers it in a small FIFO with a valid/ready host interface.

Parameters:
- MATRIX_BITS, 12, ADC result width.
- NUM_CHANNELS, 4, number of scannable channels.
- CH_BITS, 2, channel index width; must satisfy 2**CH_BITS >= NUM_CHANNELS.
- FIFO_DEPTH, 4, result FIFO entries; must be a power of 2.
- SETTLE_CYCLES, 2, cycles the core is held in reset after a channel change (minimum 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_in  in  1  single-cycle pulse; starts a scan.
- stop_in  in  1  single-cycle pulse; aborts the scan.
- continuous_in  in  1  1 = repeat the scan forever; 0 = one pass.
- chan_mask_in  in  NUM_CHANNELS  enabled channels; latched at start.
- avg_cfg_in  in  3*NUM_CHANNELS  per-channel averaging code; bits [3k+2:3k] belong to channel k.
- adc_conv_finished_in  in  1  core conversion-finished strobe; the core result is stable while it is high.
- adc_result_in  in  MATRIX_BITS  core result.
- adc_rst_n_out  out  1  registered reset to the core.
- adc_avg_control_out  out  3  averaging code to the core.
- chan_sel_out  out  CH_BITS  input mux select.
- data_out  out  CH_BITS+MATRIX_BITS  {channel, result}.
- data_valid_out  out  1  FIFO non-empty.
- data_ready_in  in  1  host pop; a pop occurs when valid and ready are both high.
- busy_out  out  1  state != IDLE.
- overflow_out  out  1  sticky; a result was dropped.

Behaviour:
- Reset values:
  - state = IDLE; adc_rst_n_out = 0.
  - chan_sel_out = 0; adc_avg_control_out = 0.
  - FIFO empty, so data_valid_out = 0 and data_out = 0.
  - busy_out = 0; overflow_out = 0; latched mask = 0; latched continuous = 0.
- States: IDLE, SETTLE, CONVERT. adc_rst_n_out is registered and is 1 only in CONVERT.
- IDLE, start_in with nonzero mask:
  - Latch chan_mask_in and continuous_in.
  - Clear overflow_out.
  - Load chan_sel_out with the lowest set channel.
  - Go to SETTLE with the settle counter = SETTLE_CYCLES.
- IDLE, start_in with zero mask: ignored.
- start_in outside IDLE: ignored.
- adc_avg_control_out = avg_cfg_in slice of chan_sel_out. It is updated together with chan_sel_out and stable for all of SETTLE and CONVERT. The core samples it during its sample phase.
- SETTLE:
  - Counter decrements each cycle.
  - When it reaches 1, go to CONVERT. adc_rst_n_out rises on that same edge.
- CONVERT:
  - Wait for adc_conv_finished_in = 1.
  - On that cycle, push {chan_sel_out, adc_result_in}. Only the first strobe per visit to CONVERT is used.
  - Pick the next channel: the lowest set mask bit above the current one.
  - If none exists: when continuous, wrap to the lowest set bit and go to SETTLE; when single-pass, go to IDLE.
  - Otherwise go to SETTLE. adc_rst_n_out falls on the same edge.
- Mask with a single bit in continuous mode: the same channel is reconverted, still passing through SETTLE each time.
- stop_in in SETTLE or CONVERT:
  - Go to IDLE next cycle; the in-flight conversion is discarded.
  - If stop_in and the strobe arrive in the same cycle, the result is still pushed.
- FIFO:
  - Push data appears on data_out the cycle after the push when the FIFO was empty (1-cycle latency).
  - First-word-fall-through; data_out is stable while valid and not ready.
- Push while full:
  - With a simultaneous pop: allowed, count unchanged.
  - Without a pop: the result is dropped and overflow_out is set. It stays set until the next accepted start_in or reset.
- Pop while empty: no effect.
- FIFO pointers wrap modulo FIFO_DEPTH. The count has log2(FIFO_DEPTH)+1 bits.
- Reset mid-scan: everything returns to reset values immediately and the core is held in reset.

Decomposition:
- Package adc_seq_pkg holds:
  - the state encoding (IDLE=2'd0, SETTLE=2'd1, CONVERT=2'd2);
  - the AVG_W = 3 constant;
  - a next-channel priority function (lowest set bit above index, with wrap flag).
- Sub-module adc_seq_fifo holds:
  - parameterised width and depth;
  - push, pop, full, empty, dout;
  - sticky overflow excluded; the overflow flag lives in the parent.

Test Plan:
1. mask=4'b0101, continuous=0, avg_cfg ch0=3'b001, ch2=3'b100, start; model returns 12'd1000 for ch0 and 12'd3000 for ch2 -> data_out 14'h03E8 then 14'h2BB8, adc_avg_control_out 1 then 4, busy_out falls after the second push, adc_rst_n_out low exactly SETTLE_CYCLES before each conversion.
2. mask=4'b1000, continuous=1, ready held high -> repeated pushes tagged channel 3, each separated by a SETTLE phase of 2 cycles low on adc_rst_n_out.
3. ready=0, continuous on mask=4'b1111 for 6 conversions -> 4 entries stored (channels 0,1,2,3), overflow_out=1 after the 5th strobe; next start_in clears it.
4. FIFO full, strobe and pop in the same cycle -> no overflow, count stays 4, the popped entry is the oldest.
5. stop_in one cycle before the strobe -> IDLE, no push, adc_rst_n_out=0; stop_in coincident with the strobe -> exactly one push.
6. Async rst_n low mid-CONVERT with 2 entries in the FIFO -> data_valid_out=0, adc_rst_n_out=0, busy_out=0 immediately; start_in with mask=0 -> stays IDLE.
